rate_meter_ctrl: RTL and testbench

RATE_METER_CTRL -- requirements
Module: rate_meter_ctrl

---
 rtl/rate_meter_pkg.sv | 12 +
 rtl/window_timer.sv | 37 +++
 rtl/rate_meter_ctrl.sv | 139 +++++++++++++
 tb/tb_rate_meter_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rate_meter_pkg.sv
// Shared types for the rate meter.
// Holds the controller FSM state encoding so the top level and any
// future siblings agree on one definition.
package rate_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/window_timer.sv
// Window timer: counts cycles of a measurement window and flags the last one.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset
//   load           : capture len and restart at index 0
//   enable         : advance one window index (wraps to 0 after the last)
//   len            : window length in cycles, already clamped to >= 1
//   tc             : current index is len-1 (last cycle of the window)
module window_timer #(
  parameter int WIN_W = 21
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load,
  input  logic             enable,
  input  logic [WIN_W-1:0] len,
  output logic             tc
);

  logic [WIN_W-1:0] len_q;
  logic [WIN_W-1:0] cnt_q;

  assign tc = (cnt_q == (len_q - WIN_W'(1)));

  // Wrapping at tc lets back-to-back windows start index 0 with no gap.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
      len_q <= WIN_W'(1);
    end else if (load) begin
      cnt_q <= '0;
      len_q <= len;
    end else if (enable) begin
      cnt_q <= tc ? '0 : (cnt_q + WIN_W'(1));
    end
  end

endmodule

// File: rtl/rate_meter_ctrl.sv
// Rate meter controller: counts rising edges of evt_in over a window of
// programmable length, single-shot or back-to-back, and hands each count
// to a consumer through a valid/ready result register.
// Ports:
//   clk_in, rst_in        : clock, asynchronous active-high reset
//   evt_in                : synchronous event level (rising edges counted)
//   start_in, stop_in     : start / abort a measurement (one-cycle pulses)
//   cont_in, win_len_in   : mode and window length, latched at start
//   result_out, sat_out   : last completed count and its saturation flag
//   result_valid_out      : result holds an unconsumed value
//   result_ready_in       : consumer accepts the result
//   overrun_out           : sticky, an unconsumed result was overwritten
//   busy_out              : a window is in progress
module rate_meter_ctrl
  import rate_meter_pkg::*;
#(
  parameter  int WIN_MAX = 1_000_000,
  parameter  int CNT_MAX = 65_535,
  localparam int WIN_W   = $clog2(WIN_MAX) + 1,
  localparam int CNT_W   = $clog2(CNT_MAX) + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             evt_in,
  input  logic             start_in,
  input  logic             stop_in,
  input  logic             cont_in,
  input  logic [WIN_W-1:0] win_len_in,
  output logic [CNT_W-1:0] result_out,
  output logic             result_valid_out,
  input  logic             result_ready_in,
  output logic             sat_out,
  output logic             overrun_out,
  output logic             busy_out
);

  function automatic logic [WIN_W-1:0] clamp_len(input logic [WIN_W-1:0] len);
    if (len == '0) begin
      return WIN_W'(1);
    end else if (len > WIN_W'(WIN_MAX)) begin
      return WIN_W'(WIN_MAX);
    end
    return len;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             inc);
    if (inc && (cnt != CNT_W'(CNT_MAX))) begin
      return cnt + CNT_W'(1);
    end
    return cnt;
  endfunction

  state_t           state_q, state_d;
  logic             evt_p1;
  logic             evt_rise;
  logic [CNT_W-1:0] evt_cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             cont_q;
  logic             start_ok;
  logic             win_end;
  logic             hs;
  logic             tc;
  logic [CNT_W-1:0] result_q;
  logic             sat_q;
  logic             vld_q;
  logic             overrun_q;

  window_timer #(.WIN_W(WIN_W)) u_timer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .load   (start_ok),
    .enable (state_q == COUNT),
    .len    (clamp_len(win_len_in)),
    .tc     (tc)
  );

  // Stage p0: edge detect, saturating increment, FSM next state
  always_comb begin
    state_d  = state_q;
    evt_rise = evt_in & ~evt_p1;
    cnt_inc  = sat_inc(evt_cnt_q, evt_rise);
    start_ok = (state_q == IDLE) && start_in;
    // stop_in wins over a coincident window end
    win_end  = (state_q == COUNT) && tc && !stop_in;
    hs       = vld_q && result_ready_in;
    case (state_q)
      IDLE:    if (start_in) state_d = COUNT;
      COUNT: begin
        if (stop_in)           state_d = IDLE;
        else if (tc && !cont_q) state_d = HOLD;
      end
      HOLD:    if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Stage p1: counters and result register
  // evt_p1 resets high so a level already high at release is not an edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      evt_p1    <= 1'b1;
      evt_cnt_q <= '0;
      cont_q    <= 1'b0;
      result_q  <= '0;
      sat_q     <= 1'b0;
      vld_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      evt_p1 <= evt_in;
      if (start_ok) begin
        cont_q    <= cont_in;
        evt_cnt_q <= '0;
      end else if (state_q == COUNT) begin
        evt_cnt_q <= (stop_in || tc) ? '0 : cnt_inc;
      end
      if (win_end) begin
        result_q <= cnt_inc;
        sat_q    <= (cnt_inc == CNT_W'(CNT_MAX));
      end
      if (win_end)  vld_q <= 1'b1;
      else if (hs)  vld_q <= 1'b0;
      if (start_ok)                       overrun_q <= 1'b0;
      else if (win_end && vld_q && !hs)   overrun_q <= 1'b1;
    end
  end

  assign result_out       = result_q;
  assign sat_out          = sat_q;
  assign result_valid_out = vld_q;
  assign overrun_out      = overrun_q;
  assign busy_out         = (state_q == COUNT);

endmodule

// File: tb/tb_rate_meter_ctrl.sv
module tb_rate_meter_ctrl;

  localparam int WIN_MAX = 63;
  localparam int CNT_MAX = 7;
  localparam int WIN_W   = $clog2(WIN_MAX) + 1;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             evt_in;
  logic             start_in;
  logic             stop_in;
  logic             cont_in;
  logic [WIN_W-1:0] win_len_in;
  logic [CNT_W-1:0] result_out;
  logic             result_valid_out;
  logic             result_ready_in;
  logic             sat_out;
  logic             overrun_out;
  logic             busy_out;

  int checks   = 0;
  int failures = 0;

  // Event level per window cycle; pat_prev is the level during the start cycle.
  bit pat [0:255];
  bit pat_prev;

  rate_meter_ctrl #(.WIN_MAX(WIN_MAX), .CNT_MAX(CNT_MAX)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .evt_in           (evt_in),
    .start_in         (start_in),
    .stop_in          (stop_in),
    .cont_in          (cont_in),
    .win_len_in       (win_len_in),
    .result_out       (result_out),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .sat_out          (sat_out),
    .overrun_out      (overrun_out),
    .busy_out         (busy_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Number of 0->1 transitions in pat[first .. first+n-1], given the level before.
  function automatic int edges_in(input int first, input int n, input bit prev0);
    int e;
    bit prev;
    e    = 0;
    prev = prev0;
    for (int i = first; i < first + n; i++) begin
      if (pat[i] && !prev) e++;
      prev = pat[i];
    end
    return e;
  endfunction

  function automatic int clip(input int e);
    return (e > CNT_MAX) ? CNT_MAX : e;
  endfunction

  task automatic start_window(input int len_in, input bit cont);
    evt_in     = pat_prev;
    win_len_in = WIN_W'(len_in);
    cont_in    = cont;
    start_in   = 1'b1;
    step();
    start_in = 1'b0;
    cont_in  = ~cont;   // must have been latched already
  endtask

  // One single-shot window of w cycles over pat[0..w-1], then hold cycles with
  // ready low (toggling evt, pulsing start then stop), then consume.
  task automatic single_shot(input int len_in, input int w, input int hold, input string tag);
    int e;
    int exp_res;
    bit exp_sat;
    e       = edges_in(0, w, pat_prev);
    exp_res = clip(e);
    exp_sat = (e >= CNT_MAX);
    result_ready_in = 1'b0;
    start_window(len_in, 1'b0);
    for (int i = 0; i < w; i++) begin
      evt_in = pat[i];
      if (i == w - 1) begin
        checks++;
        if (busy_out !== 1'b1 || result_valid_out !== 1'b0) begin
          failures++;
          $display("FAIL %s_last_index busy=%b valid=%b exp busy=1 valid=0", tag, busy_out, result_valid_out);
        end
      end
      step();
    end
    checks++;
    if (result_valid_out !== 1'b1 || busy_out !== 1'b0) begin
      failures++;
      $display("FAIL %s_end valid=%b busy=%b exp valid=1 busy=0", tag, result_valid_out, busy_out);
    end
    checks++;
    if (result_out !== CNT_W'(exp_res)) begin
      failures++;
      $display("FAIL %s_result got=%0d exp=%0d", tag, result_out, exp_res);
    end
    checks++;
    if (sat_out !== exp_sat) begin
      failures++;
      $display("FAIL %s_sat got=%b exp=%b", tag, sat_out, exp_sat);
    end
    for (int h = 0; h < hold; h++) begin
      evt_in   = ~evt_in;
      start_in = (h == 0);
      stop_in  = (h == 1);
      step();
      start_in = 1'b0;
      stop_in  = 1'b0;
      checks++;
      if (result_valid_out !== 1'b1 || busy_out !== 1'b0 ||
          result_out !== CNT_W'(exp_res) || sat_out !== exp_sat) begin
        failures++;
        $display("FAIL %s_hold%0d valid=%b busy=%b res=%0d sat=%b exp valid=1 busy=0 res=%0d sat=%b",
                 tag, h, result_valid_out, busy_out, result_out, sat_out, exp_res, exp_sat);
      end
    end
    result_ready_in = 1'b1;
    step();
    result_ready_in = 1'b0;
    checks++;
    if (result_valid_out !== 1'b0 || busy_out !== 1'b0) begin
      failures++;
      $display("FAIL %s_consume valid=%b busy=%b exp valid=0 busy=0", tag, result_valid_out, busy_out);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0; evt_in = 1'b0; start_in = 1'b0; stop_in = 1'b0;
    cont_in = 1'b0; win_len_in = '0; result_ready_in = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    checks++;
    if ({result_out, result_valid_out, sat_out, overrun_out, busy_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs res=%0d valid=%b sat=%b ovr=%b busy=%b exp all 0",
               result_out, result_valid_out, sat_out, overrun_out, busy_out);
    end
    step();
    step();
    #2 rst_in = 1'b0;
    step();
  endtask

  task automatic test_single();
    for (int i = 0; i < 10; i++) pat[i] = 1'b0;
    pat[2] = 1'b1; pat[5] = 1'b1; pat[8] = 1'b1;
    pat_prev = 1'b0;
    single_shot(10, 10, 3, "single");
  endtask

  task automatic test_boundary();
    pat_prev = 1'b0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b0; pat[4] = 1'b1;
    single_shot(5, 5, 0, "bound_edges");
    // last index low, the first hold cycle raises evt (index 5, outside window)
    pat[4] = 1'b0;
    single_shot(5, 5, 2, "bound_after");
  endtask

  task automatic test_saturation();
    pat_prev = 1'b0;
    for (int i = 0; i < 40; i++) pat[i] = (i % 2 == 0);
    single_shot(40, 40, 0, "sat");
  endtask

  task automatic test_clamp();
    pat_prev = 1'b0;
    pat[0]   = 1'b1;
    single_shot(0, 1, 0, "clamp_zero");
    pat_prev = $urandom_range(0, 1);
    for (int i = 0; i < WIN_MAX; i++) pat[i] = $urandom_range(0, 1);
    single_shot(127, WIN_MAX, 0, "clamp_max");
  endtask

  task automatic test_continuous();
    int e1;
    int e2;
    pat_prev = $urandom_range(0, 1);
    for (int i = 0; i < 8; i++) pat[i] = $urandom_range(0, 1);
    e1 = clip(edges_in(0, 4, pat_prev));
    e2 = clip(edges_in(4, 4, pat[3]));
    result_ready_in = 1'b0;
    start_window(4, 1'b1);
    for (int i = 0; i < 4; i++) begin evt_in = pat[i]; step(); end
    checks++;
    if (result_valid_out !== 1'b1 || result_out !== CNT_W'(e1) || overrun_out !== 1'b0 || busy_out !== 1'b1) begin
      failures++;
      $display("FAIL cont_win1 valid=%b res=%0d ovr=%b busy=%b exp 1 %0d 0 1",
               result_valid_out, result_out, overrun_out, busy_out, e1);
    end
    for (int i = 4; i < 8; i++) begin evt_in = pat[i]; step(); end
    checks++;
    if (result_valid_out !== 1'b1 || result_out !== CNT_W'(e2) || overrun_out !== 1'b1 || busy_out !== 1'b1) begin
      failures++;
      $display("FAIL cont_overrun valid=%b res=%0d ovr=%b busy=%b exp 1 %0d 1 1",
               result_valid_out, result_out, overrun_out, busy_out, e2);
    end
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    checks++;
    if (busy_out !== 1'b0 || result_valid_out !== 1'b1 || result_out !== CNT_W'(e2)) begin
      failures++;
      $display("FAIL cont_stop_keeps busy=%b valid=%b res=%0d exp 0 1 %0d", busy_out, result_valid_out, result_out, e2);
    end
    result_ready_in = 1'b1;
    step();
    result_ready_in = 1'b0;
    checks++;
    if (result_valid_out !== 1'b0 || overrun_out !== 1'b1) begin
      failures++;
      $display("FAIL cont_sticky valid=%b ovr=%b exp valid=0 ovr=1", result_valid_out, overrun_out);
    end
    // Second run: handshake in the load cycle, no overrun.
    pat_prev = $urandom_range(0, 1);
    for (int i = 0; i < 8; i++) pat[i] = $urandom_range(0, 1);
    e1 = clip(edges_in(0, 4, pat_prev));
    e2 = clip(edges_in(4, 4, pat[3]));
    start_window(4, 1'b1);
    checks++;
    if (overrun_out !== 1'b0) begin
      failures++;
      $display("FAIL cont_start_clears got=%b exp=0", overrun_out);
    end
    for (int i = 0; i < 4; i++) begin evt_in = pat[i]; step(); end
    for (int i = 4; i < 8; i++) begin
      evt_in = pat[i];
      result_ready_in = (i == 7);
      step();
    end
    result_ready_in = 1'b0;
    checks++;
    if (result_valid_out !== 1'b1 || result_out !== CNT_W'(e2) || overrun_out !== 1'b0) begin
      failures++;
      $display("FAIL cont_hs_load valid=%b res=%0d ovr=%b exp 1 %0d 0", result_valid_out, result_out, overrun_out, e2);
    end
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    result_ready_in = 1'b1;
    step();
    result_ready_in = 1'b0;
  endtask

  task automatic test_stop();
    int bad;
    pat_prev = 1'b0;
    start_window(6, 1'b0);
    evt_in = 1'b1; step();
    evt_in = 1'b0; step();
    evt_in = 1'b1; stop_in = 1'b1; step();
    stop_in = 1'b0;
    checks++;
    if (busy_out !== 1'b0 || result_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL stop_idx2 busy=%b valid=%b exp 0 0", busy_out, result_valid_out);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      evt_in = ~evt_in;
      step();
      if (result_valid_out !== 1'b0 || busy_out !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stop_idx2_after bad_cycles=%0d exp=0", bad);
    end
    start_window(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      evt_in  = (i % 2 == 0);
      stop_in = (i == 3);
      step();
    end
    stop_in = 1'b0;
    checks++;
    if (busy_out !== 1'b0 || result_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL stop_at_end busy=%b valid=%b exp 0 0", busy_out, result_valid_out);
    end
    step();
    step();
    checks++;
    if (result_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL stop_at_end_after valid=%b exp 0", result_valid_out);
    end
  endtask

  task automatic test_random();
    int w;
    int e;
    int s;
    int m_res;
    bit m_valid;
    bit m_sat;
    bit m_ovr;
    bit rdy;
    bit hs;
    bit prev;
    for (int it = 0; it < 4; it++) begin
      w        = $urandom_range(1, 30);
      pat_prev = $urandom_range(0, 1);
      for (int i = 0; i < w; i++) pat[i] = $urandom_range(0, 1);
      single_shot(w, w, 0, "rand_single");
    end
    for (int it = 0; it < 6; it++) begin
      w        = $urandom_range(1, 16);
      pat_prev = $urandom_range(0, 1);
      for (int i = 0; i < 3 * w; i++) pat[i] = $urandom_range(0, 1);
      m_valid = 1'b0; m_ovr = 1'b0; m_sat = 1'b0; m_res = 0;
      result_ready_in = 1'b0;
      start_window(w, 1'b1);
      for (int k = 0; k < 3 * w; k++) begin
        evt_in = pat[k];
        rdy    = $urandom_range(0, 1);
        result_ready_in = rdy;
        hs = m_valid && rdy;
        if (k % w == w - 1) begin
          s = k - w + 1;
          if (s == 0) prev = pat_prev;
          else        prev = pat[s - 1];
          e = edges_in(s, w, prev);
          if (m_valid && !hs) m_ovr = 1'b1;
          m_valid = 1'b1;
          m_res   = clip(e);
          m_sat   = (e >= CNT_MAX);
        end else if (hs) begin
          m_valid = 1'b0;
        end
        step();
        checks++;
        if (result_valid_out !== m_valid || overrun_out !== m_ovr || busy_out !== 1'b1) begin
          failures++;
          $display("FAIL rand_cont_ctrl it=%0d k=%0d valid=%b ovr=%b busy=%b exp %b %b 1",
                   it, k, result_valid_out, overrun_out, busy_out, m_valid, m_ovr);
        end
        if (m_valid) begin
          checks++;
          if (result_out !== CNT_W'(m_res) || sat_out !== m_sat) begin
            failures++;
            $display("FAIL rand_cont_result it=%0d k=%0d res=%0d sat=%b exp %0d %b",
                     it, k, result_out, sat_out, m_res, m_sat);
          end
        end
      end
      result_ready_in = 1'b0;
      stop_in = 1'b1;
      step();
      stop_in = 1'b0;
      checks++;
      if (busy_out !== 1'b0 || result_valid_out !== m_valid) begin
        failures++;
        $display("FAIL rand_cont_stop busy=%b valid=%b exp 0 %b", busy_out, result_valid_out, m_valid);
      end
      result_ready_in = 1'b1;
      step();
      result_ready_in = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    pat_prev = 1'b0;
    for (int i = 0; i < 36; i++) pat[i] = (i % 2 == 0);
    result_ready_in = 1'b0;
    start_window(16, 1'b1);
    for (int i = 0; i < 35; i++) begin evt_in = pat[i]; step(); end
    checks++;
    if (result_valid_out !== 1'b1 || overrun_out !== 1'b1 || sat_out !== 1'b1 ||
        result_out !== CNT_W'(CNT_MAX) || busy_out !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre valid=%b ovr=%b sat=%b res=%0d busy=%b exp 1 1 1 %0d 1",
               result_valid_out, overrun_out, sat_out, result_out, busy_out, CNT_MAX);
    end
    evt_in = 1'b1;
    #2 rst_in = 1'b1;
    #1;
    checks++;
    if ({result_out, result_valid_out, sat_out, overrun_out, busy_out} !== '0) begin
      failures++;
      $display("FAIL areset_immediate res=%0d valid=%b sat=%b ovr=%b busy=%b exp all 0",
               result_out, result_valid_out, sat_out, overrun_out, busy_out);
    end
    step();
    #2 rst_in = 1'b0;
    step();
    checks++;
    if (result_valid_out !== 1'b0 || busy_out !== 1'b0) begin
      failures++;
      $display("FAIL areset_release valid=%b busy=%b exp 0 0", result_valid_out, busy_out);
    end
    pat_prev = 1'b1;
    for (int i = 0; i < 4; i++) pat[i] = 1'b1;
    single_shot(4, 4, 0, "areset_level_high");
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_saturation();
    test_clamp();
    test_continuous();
    test_stop();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
